// File: rtl/ldtu_ofifo_secded.sv
// ldtu_ofifo_secded -- LiTe-DTU output FIFO with SEC-DED protected storage.
//
// Sits between the CU word packer and the serialiser. Words are Hamming
// encoded on the way in and decoded/corrected on the way out. Flush and synch
// clear the queue and force a pattern onto DATA_OUT.
//
// Optional feature: define LDTU_OFIFO_ERRCNT_EN to add the saturating
// sec_cnt / ded_cnt error counters. These are cleared only by reset.
//
// Ports
//   CLK, reset      clock, synchronous active-high reset
//   write_signal    push data_in (dropped if full with no pop)
//   data_in         DATA_W word to store
//   read_signal     pop head, DATA_OUT updated one edge later
//   flush_b         active-low flush: clear FIFO, DATA_OUT=FLUSH_PAT
//   synch           clear FIFO, DATA_OUT=synch_pattern
//   synch_pattern   word presented during synch
//   DATA_OUT        registered output word
//   full_signal / almost_full / empty_signal   occupancy status
//   overflow        sticky write-while-full flag (kept across flush/synch)
//   SeuError        pulse: corrected single-bit error on this DATA_OUT
//   DedError        pulse: uncorrectable double-bit error on this DATA_OUT
//   sec_cnt/ded_cnt 8-bit saturating error counters (optional)
//
// Codeword layout: bit 0 is the overall parity. Bits 1..CW_W-1 are Hamming
// positions. Powers of two hold check bits, and the remaining positions hold
// data, LSB first.
module ldtu_ofifo_secded #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter logic [DATA_W-1:0] IDLE_PAT  = DATA_W'(32'hEAAAAAAA),
  parameter logic [DATA_W-1:0] FLUSH_PAT = DATA_W'(32'h2CF0F0F0)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              write_signal,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_signal,
  input  logic              flush_b,
  input  logic              synch,
  input  logic [DATA_W-1:0] synch_pattern,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              full_signal,
  output logic              almost_full,
  output logic              empty_signal,
  output logic              overflow,
  output logic              SeuError,
  output logic              DedError
`ifdef LDTU_OFIFO_ERRCNT_EN
  ,
  output logic [7:0]        sec_cnt,
  output logic [7:0]        ded_cnt
`endif
);

  function automatic int calc_r(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int R    = calc_r(DATA_W);
  localparam int CW_W = DATA_W + R + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_THRESH[AW:0];

  typedef logic [CW_W-1:0] cw_t;

  function automatic cw_t encode(input logic [DATA_W-1:0] d);
    cw_t c;
    int  k;
    c = '0;
    k = 0;
    for (int i = 1; i < CW_W; i++)
      if ((i & (i - 1)) != 0) begin
        c[i] = d[k];
        k++;
      end
    for (int j = 0; j < R; j++)
      for (int i = 1; i < CW_W; i++)
        if ((((i >> j) & 1) == 1) && ((i & (i - 1)) != 0))
          c[1 << j] = c[1 << j] ^ c[i];
    c[0] = ^c[CW_W-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input cw_t c);
    logic [DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < CW_W; i++)
      if ((i & (i - 1)) != 0) begin
        d[k] = c[i];
        k++;
      end
    return d;
  endfunction

  cw_t           mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  assign full_signal  = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign empty_signal = (count == '0);

  // Flush and synch suppress any FIFO traffic that cycle.
  logic fifo_run, do_pop, do_push;
  assign fifo_run = !reset && flush_b && !synch;
  assign do_pop   = fifo_run && read_signal && !empty_signal;
  assign do_push  = fifo_run && write_signal && (!full_signal || do_pop);

  // Decode the head entry.
  cw_t               cw_rd, cw_fix;
  logic [R-1:0]      syn;
  logic              par, dec_sec, dec_ded;
  logic [DATA_W-1:0] dec_data;

  always_comb begin
    cw_rd = mem[rptr];
    syn   = '0;
    for (int i = 1; i < CW_W; i++)
      if (cw_rd[i]) syn = syn ^ R'(i);
    par    = ^cw_rd;
    cw_fix = cw_rd;
    // A syndrome beyond the codeword is really a multi-bit error.
    // Leave such data untouched.
    if (par && (int'(syn) < CW_W)) cw_fix[syn] = ~cw_fix[syn];
    dec_data = extract(cw_fix);
    dec_sec  = par;
    dec_ded  = !par && (syn != '0);
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= encode(data_in);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      DATA_OUT <= IDLE_PAT;
      overflow <= 1'b0;
      SeuError <= 1'b0;
      DedError <= 1'b0;
    end else if (!flush_b || synch) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      DATA_OUT <= !flush_b ? FLUSH_PAT : synch_pattern;
      SeuError <= 1'b0;
      DedError <= 1'b0;
    end else begin
      SeuError <= 1'b0;
      DedError <= 1'b0;
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        DATA_OUT <= dec_data;
        rptr     <= rptr + 1'b1;
        SeuError <= dec_sec;
        DedError <= dec_ded;
      end else if (read_signal) begin
        // No fall-through: a read of an empty FIFO returns idle.
        DATA_OUT <= IDLE_PAT;
      end
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
      if (write_signal && full_signal && !do_pop) overflow <= 1'b1;
    end
  end

`ifdef LDTU_OFIFO_ERRCNT_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else begin
      if (do_pop && dec_sec && sec_cnt != 8'hFF) sec_cnt <= sec_cnt + 8'd1;
      if (do_pop && dec_ded && ded_cnt != 8'hFF) ded_cnt <= ded_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ldtu_ofifo_secded.sv
module tb_ldtu_ofifo_secded;
  localparam logic [31:0] IDLE  = 32'hEAAAAAAA;
  localparam logic [31:0] FLUSH = 32'h2CF0F0F0;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        write_signal = 1'b0, read_signal = 1'b0;
  logic        flush_b = 1'b1, synch = 1'b0;
  logic [31:0] data_in = '0, synch_pattern = '0;
  logic [31:0] DATA_OUT;
  logic        full_signal, almost_full, empty_signal, overflow, SeuError, DedError;
`ifdef LDTU_OFIFO_ERRCNT_EN
  logic [7:0]  sec_cnt, ded_cnt;
`endif

  ldtu_ofifo_secded dut (
    .CLK(CLK), .reset(reset), .write_signal(write_signal), .data_in(data_in),
    .read_signal(read_signal), .flush_b(flush_b), .synch(synch),
    .synch_pattern(synch_pattern), .DATA_OUT(DATA_OUT),
    .full_signal(full_signal), .almost_full(almost_full),
    .empty_signal(empty_signal), .overflow(overflow),
    .SeuError(SeuError), .DedError(DedError)
`ifdef LDTU_OFIFO_ERRCNT_EN
    , .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard entries. The expected word and error pulses for each read issued.
  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] model[$];

  logic rd_d = 1'b0;
  always @(posedge CLK) rd_d <= read_signal & flush_b & ~synch & ~reset;

  always @(negedge CLK) begin
    exp_t e;
    if (rd_d) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("data_out", DATA_OUT, e.d);
        chk("seu_pulse", {31'd0, SeuError}, {31'd0, e.s});
        chk("ded_pulse", {31'd0, DedError}, {31'd0, e.e});
      end
    end else begin
      chk("seu_idle", {31'd0, SeuError}, 32'd0);
      chk("ded_idle", {31'd0, DedError}, 32'd0);
    end
  end

  // One cycle of traffic. The reference queue supplies the expected read word.
  // xm is XORed into it for uncorrectable-error reads.
  task automatic cyc(input logic wr, input logic [31:0] din, input logic rd,
                     input logic es = 1'b0, input logic ed = 1'b0,
                     input logic [31:0] xm = 32'd0);
    int   sz;
    logic popped;
    exp_t e;
    write_signal = wr;
    data_in      = din;
    read_signal  = rd;
    popped       = 1'b0;
    if (flush_b && !synch) begin
      sz = model.size();
      if (rd) begin
        if (sz == 0) begin
          e.d = IDLE; e.s = 1'b0; e.e = 1'b0;
        end else begin
          e.d = model.pop_front() ^ xm; e.s = es; e.e = ed;
          popped = 1'b1;
        end
        sb.push_back(e);
      end
      if (wr && (sz < 16 || popped)) model.push_back(din);
    end
    @(negedge CLK);
    write_signal = 1'b0;
    read_signal  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    model.delete();
  endtask

  initial begin
    @(negedge CLK);
    do_reset();
    // 1: reset state
    chk("rst_data", DATA_OUT, IDLE);
    chk("rst_empty", {31'd0, empty_signal}, 32'd1);
    chk("rst_full", {31'd0, full_signal}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_af", {31'd0, almost_full}, 32'd0);

    // 2: fill, overflow, drain, then read empty
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, i, 1'b0);
      chk("fill_af", {31'd0, almost_full}, {31'd0, (i + 1) >= 14});
      chk("fill_full", {31'd0, full_signal}, {31'd0, (i + 1) == 16});
    end
    chk("pre_ovf", {31'd0, overflow}, 32'd0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_full", {31'd0, full_signal}, 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 1'b1);
    chk("drain_empty", {31'd0, empty_signal}, 32'd1);
    cyc(1'b0, 0, 1'b1);
    chk("empty_rd", DATA_OUT, IDLE);

    // 4: flush with traffic active, overflow retained, then synch
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + i, 1'b0);
    flush_b = 1'b0;
    model.delete();
    cyc(1'b1, 32'h5555_0000, 1'b1);
    cyc(1'b1, 32'h5555_0001, 1'b1);
    chk("flush_data", DATA_OUT, FLUSH);
    chk("flush_empty", {31'd0, empty_signal}, 32'd1);
    chk("flush_ovf_kept", {31'd0, overflow}, 32'd1);
    flush_b = 1'b1;
    cyc(1'b0, 0, 1'b1);
    chk("post_flush_rd", DATA_OUT, IDLE);
    cyc(1'b1, 32'h77, 1'b0);
    synch = 1'b1;
    synch_pattern = 32'h1234_5678;
    model.delete();
    cyc(1'b1, 32'h99, 1'b1);
    chk("synch_data", DATA_OUT, 32'h1234_5678);
    chk("synch_empty", {31'd0, empty_signal}, 32'd1);
    synch = 1'b0;

    // 3: single and double error injection at mem[0]/mem[1]
    do_reset();
    cyc(1'b1, 32'hA5A5_A5A5, 1'b0);
    cyc(1'b1, 32'h3C3C_0F0F, 1'b0);
    // The codeword positions are 12 for data bit 7, 7 for data bit 3,
    // and 26 for data bit 20.
    dut.mem[0][12] = ~dut.mem[0][12];
    dut.mem[1][7]  = ~dut.mem[1][7];
    dut.mem[1][26] = ~dut.mem[1][26];
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 32'h0010_0008);
    cyc(1'b0, 0, 1'b0);

    // 5: full-rate read+write at count 16 across pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h200 + i, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h300 + i, 1'b1);
      chk("rw_full", {31'd0, full_signal}, 32'd1);
    end
    chk("rw_no_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 1'b1);
    chk("rw_empty", {31'd0, empty_signal}, 32'd1);

`ifdef LDTU_OFIFO_ERRCNT_EN
    // 6: counter saturation, unaffected by flush
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 32'hC0DE_0000 + i, 1'b0);
      dut.mem[i % 16][i % 39] = ~dut.mem[i % 16][i % 39];
      cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    end
    cyc(1'b0, 0, 1'b0);
    chk("sec_sat", {24'd0, sec_cnt}, 32'd255);
    chk("ded_zero", {24'd0, ded_cnt}, 32'd0);
    flush_b = 1'b0;
    cyc(1'b0, 0, 1'b0);
    flush_b = 1'b1;
    cyc(1'b0, 0, 1'b0);
    chk("sec_flush", {24'd0, sec_cnt}, 32'd255);
    chk("ded_flush", {24'd0, ded_cnt}, 32'd0);
`endif

    repeat (2) @(negedge CLK);
    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
